// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and latency constants for the systolic controller
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int PE_HOP_LAT = 2;
    localparam int BUF_RD_LAT = 1;

    // Extra FEED cycles beyond K needed to skew the last row in.
    function automatic int feed_extra(input int n);
        return PE_HOP_LAT * (n - 1);
    endfunction

    // Skew out of the far corner plus the read and accumulate stages.
    function automatic int drain_len(input int n);
        return PE_HOP_LAT * n + 2 * BUF_RD_LAT;
    endfunction

endpackage

// File: rtl/systolic_ctrl_skew_addr_gen.sv
// rtl/systolic_ctrl_skew_addr_gen.sv - per-row skewed read strobe and address from the FEED counter
module skew_addr_gen
    import systolic_pkg::*;
#(
    parameter int KW  = 8,
    parameter int TW  = 10,
    parameter int ROW = 0
) (
    input  logic          feed_i,
    input  logic [TW-1:0] t_i,
    input  logic [KW-1:0] k_i,
    output logic          rd_en_o,
    output logic [KW-1:0] rd_addr_o
);

    localparam logic [TW-1:0] OFF = TW'(PE_HOP_LAT * ROW);

    logic [TW-1:0] rel;
    logic          in_win;

    assign rel       = t_i - OFF;
    assign in_win    = feed_i && (t_i >= OFF) && (rel < TW'(k_i));
    assign rd_en_o   = in_win;
    assign rd_addr_o = in_win ? rel[KW-1:0] : '0;

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for an N x N output-stationary systolic matmul
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = 2,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [KW-1:0]   k_len_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pe_clr_o,
    output logic            pe_en_o,
    output logic [N-1:0]    rd_en_o,
    output logic [N*KW-1:0] rd_addr_o,
    output logic [N-1:0]    op_vld_o
);

    // Wide enough for 2^KW-1 + 2(N-1) without wrapping.
    localparam int TW = KW + $clog2(N) + 1;
    localparam int DL = drain_len(N);
    localparam int DW = $clog2(DL);

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [TW-1:0] t_q;
    logic [DW-1:0] d_q;
    logic          busy_q, done_q, pe_clr_q, pe_en_q;
    logic [N-1:0]  op_vld_q;
    logic [TW-1:0] feed_last;

    assign feed_last = TW'(k_q) + TW'(feed_extra(N)) - TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            t_q      <= '0;
            d_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pe_clr_q <= 1'b1;
            pe_en_q  <= 1'b0;
        end else if (abort_i && state_q != ST_IDLE) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            d_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pe_clr_q <= 1'b0;
            pe_en_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    pe_clr_q <= 1'b0;
                    pe_en_q  <= 1'b0;
                    t_q      <= '0;
                    d_q      <= '0;
                    if (start_i) begin
                        state_q  <= ST_CLEAR;
                        k_q      <= k_len_i;
                        busy_q   <= 1'b1;
                        pe_clr_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    pe_clr_q <= 1'b0;
                    if (k_q != '0) begin
                        state_q <= ST_FEED;
                        pe_en_q <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_FEED: begin
                    t_q <= t_q + TW'(1);
                    if (t_q == feed_last) begin
                        state_q <= ST_DRAIN;
                        d_q     <= '0;
                    end
                end
                ST_DRAIN: begin
                    d_q <= d_q + DW'(1);
                    if (d_q == DW'(DL - 1)) begin
                        state_q <= ST_DONE;
                        pe_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        skew_addr_gen #(.KW(KW), .TW(TW), .ROW(i)) u_skew (
            .feed_i   (state_q == ST_FEED),
            .t_i      (t_q),
            .k_i      (k_q),
            .rd_en_o  (rd_en_o[i]),
            .rd_addr_o(rd_addr_o[i*KW +: KW])
        );
    end

    // Tracks the one-cycle operand buffer read.
    always_ff @(posedge clk) begin
        if (rst) op_vld_q <= '0;
        else     op_vld_q <= rd_en_o;
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign pe_clr_o = pe_clr_q;
    assign pe_en_o  = pe_en_q;
    assign op_vld_o = op_vld_q;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 2: systolic array dimension (N x N pe instances).
REQ-002 Parameter KW, default 8: width of k_len and of each row read address.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to run one matrix multiply; sampled only in IDLE.
REQ-006 k_len  input  KW  inner dimension K; sampled and latched with start.
REQ-007 abort  input  1  cancel the current job; returns to IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; all N*N pe c_out values are final.
REQ-010 pe_clr  output  1  drives rst of every pe; clears the accumulators.
REQ-011 pe_en  output  1  drives en of every pe.
REQ-012 rd_en  output  N  per-row operand read strobe, shared by A-row i and B-column i buffers.
REQ-013 rd_addr  output  N*KW  per-row read address; row i occupies bits [i*KW +: KW].
REQ-014 op_vld  output  N  rd_en delayed one cycle; datapath feeds operand 0 when op_vld[i]=0.

Function
REQ-015 States: IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-016 IDLE -> CLEAR when start=1; k_len latched on the same edge.
REQ-017 CLEAR lasts 1 cycle with pe_clr=1 and pe_en=0.
REQ-018 CLEAR -> FEED if K>0; CLEAR -> DONE if K=0 (results all zero).
REQ-019 A FEED cycle counter t starts at 0 in the first FEED cycle. FEED lasts K+2(N-1) cycles; DRAIN lasts 2N+2 cycles; pe_en=1 throughout FEED and DRAIN.
REQ-020 In FEED, rd_en[i]=1 iff 2i <= t < 2i+K, with rd_addr[i]=t-2i; otherwise rd_en[i]=0 and rd_addr[i]=0.
REQ-021 op_vld[i] SHALL be rd_en[i] registered; buffer read latency is exactly 1 cycle.
REQ-022 DONE lasts 1 cycle: done=1, pe_en=0, busy=1; then -> IDLE. The first cycle of DONE is FEED-relative cycle K+4N.
REQ-023 pe_en=0 in IDLE and DONE, so pe c_out holds its value until the next CLEAR.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 abort=1 in any busy state SHALL force IDLE on the next edge with no done pulse. abort has priority over every other transition, including DONE.
REQ-026 start and abort both high in IDLE: start wins; abort is ignored in IDLE.
REQ-027 Counters SHALL be sized for a maximum t of 2^KW-1+2(N-1) without wrap.

Reset
REQ-028 rst=1 SHALL, on the next edge and regardless of state, set state=IDLE and clear counters and the latched K.
REQ-029 Outputs while rst=1 and one cycle after: busy=0, done=0, pe_en=0, rd_en=0, rd_addr=0, op_vld=0, pe_clr=1.
REQ-030 In IDLE after reset, pe_clr=0.

Structure
REQ-031 State encoding and the latency constants SHALL live in the shared package systolic_pkg: per-hop pe latency 2, buffer read latency 1, DRAIN length formula.
REQ-032 One sub-module is natural: skew_addr_gen (per-row rd_en/rd_addr from t, K, row index), instantiated N times.

Verification
REQ-033 N=2, K=4, start at cycle 0 -> CLEAR at cycle 1; row0 rd_addr 0..3 at cycles 2..5; row1 rd_addr 0..3 at cycles 4..7; done at cycle 14; 2x2 results match a golden matmul.
REQ-034 K=0 -> CLEAR at cycle 1, done at cycle 2, rd_en never asserted, all c_out=0.
REQ-035 Second start pulses at cycles 3 and 10 of a K=4 job -> ignored; exactly one done, still at cycle 14.
REQ-036 abort at cycle 6 of a K=4 job -> IDLE at cycle 7, no done; a new start then yields correct results.
REQ-037 rst asserted during DRAIN -> IDLE on the next edge and all outputs at their reset values; K=255 job -> done at FEED-relative cycle 263, with no counter wrap.
